// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive blocks.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Rounded clocks-per-bit divisor.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte stream valid/ready handshake feeding the UART transmitter.
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pop data is registered from the head entry on the pop edge.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      push_data_i,
  input  logic                   pop_i,
  output logic [DATA_W-1:0]      pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              push_ok, pop_ok;

  assign full_o     = (level_q == (AW+1)'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign level_o    = level_q;
  assign pop_data_o = pop_data_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    pop_data_d = pop_data_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      pop_data_d = mem[rd_ptr_q];
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pop_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pop_data_q <= pop_data_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: stream bytes into a FIFO, serialise 8 data bits LSB first
// with optional parity and 1 or 2 stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int FIFO_DEPTH  = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                        clk_i,
  input  logic                        arst_n_i,
  uart_tx_fifo_if.slave               s_if,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);
  localparam int      DIV      = calc_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int      BAUD_W   = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam parity_e PAR_MODE = parity_e'(2'(PARITY));

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_fifo: clocks per bit must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_stop_chk
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              stop_q, stop_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              fifo_pop, fifo_full, fifo_empty, baud_end;
  logic [DATA_W-1:0] head;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .push_i      (s_if.valid),
    .push_data_i (s_if.data),
    .pop_i       (fifo_pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level_o)
  );

  assign s_if.ready = ~fifo_full;
  assign baud_end   = (baud_q == BAUD_W'(DIV - 1));
  assign tx_o       = tx_q;
  assign busy_o     = (state_q != ST_IDLE) | (level_o != '0);

  // The popped byte stays on head for the whole frame, so parity reads it directly.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_end ? '0 : baud_q + 1'b1;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    tx_d     = 1'b1;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
          shift_d = head;
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (baud_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          stop_d  = 1'b0;
          if (bit_q == 3'd7) state_d = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        tx_d = (PAR_MODE == PAR_ODD) ? ~^head : ^head;
        if (baud_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (baud_end) begin
          if (stop_q == 1'(STOP_BITS - 1)) state_d = ST_IDLE;
          else                             stop_d  = stop_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Four transmitter instances (8N1, 8E1, 8O1, 8N2) at 10 clocks per bit, each with a
// scoreboard queue filled on accepted pushes and a line decoder that pops and compares.
module tb_uart_tx_fifo;

  localparam int DIV = 10;
  localparam int N   = 4;
  localparam int PAR_T [N] = '{0, 1, 2, 0};
  localparam int STB_T [N] = '{1, 1, 1, 2};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   data_a [N];
  logic [N-1:0] valid_a;
  wire  [N-1:0] ready_a;
  wire  [N-1:0] tx_a;
  wire  [N-1:0] busy_a;
  wire  [3:0]   level_a [N];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g
    localparam int PAR   = PAR_T[gi];
    localparam int STB   = STB_T[gi];
    localparam int FRAME = DIV * (9 + ((PAR != 0) ? 1 : 0) + STB);

    uart_tx_fifo_if ifc ();
    assign ifc.data    = data_a[gi];
    assign ifc.valid   = valid_a[gi];
    assign ready_a[gi] = ifc.ready;

    uart_tx_fifo #(
      .CLK_FREQ_HZ (1_000_000),
      .BAUD_RATE   (100_000),
      .FIFO_DEPTH  (8),
      .PARITY      (PAR),
      .STOP_BITS   (STB)
    ) dut (
      .clk_i    (clk),
      .arst_n_i (rst_n),
      .s_if     (ifc),
      .tx_o     (tx_a[gi]),
      .busy_o   (busy_a[gi]),
      .level_o  (level_a[gi])
    );

    logic [7:0] exp_q [$];

    always @(posedge clk) begin
      if (rst_n && valid_a[gi] && ready_a[gi]) exp_q.push_back(data_a[gi]);
    end

    always @(negedge clk) begin
      if (rst_n) chk($sformatf("ready_vs_level_u%0d", gi), ready_a[gi], (level_a[gi] < 4'd8) ? 1 : 0);
    end

    // Line decoder: samples mid-bit, checks framing, back-to-back spacing and byte order.
    initial begin : mon
      int         last_fall;
      logic [7:0] b;
      last_fall = -100000;
      forever begin
        @(negedge clk);
        if (rst_n && !tx_a[gi]) begin
          if (cyc - last_fall <= FRAME + 5)
            chk($sformatf("frame_gap_u%0d", gi), cyc - last_fall, FRAME + 1);
          last_fall = cyc;
          repeat (DIV / 2 - 1) @(negedge clk);
          chk($sformatf("start_bit_u%0d", gi), tx_a[gi], 0);
          for (int k = 0; k < 8; k++) begin
            repeat (DIV) @(negedge clk);
            b[k] = tx_a[gi];
          end
          if (PAR != 0) begin
            repeat (DIV) @(negedge clk);
            chk($sformatf("parity_u%0d", gi), tx_a[gi], (PAR == 1) ? int'(^b) : int'(~^b));
          end
          for (int s = 0; s < STB; s++) begin
            repeat (DIV) @(negedge clk);
            chk($sformatf("stop_bit_u%0d", gi), tx_a[gi], 1);
          end
          if (exp_q.size() == 0) chk($sformatf("frame_expected_u%0d", gi), 0, 1);
          else                   chk($sformatf("rx_byte_u%0d", gi), b, exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_one(input int idx, input logic [7:0] b);
    int budget;
    budget = 500;
    data_a[idx]  = b;
    valid_a[idx] = 1'b1;
    while (!ready_a[idx] && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    chk("push_ready_seen", ready_a[idx], 1);
    @(posedge clk);
    #1;
    valid_a[idx] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         t0, t1, tb0, t3, waited;
    logic [7:0] burst [10];
    bit         pat_a5 [10];
    burst  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    pat_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    valid_a = '0;
    for (int i = 0; i < N; i++) data_a[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk("reset_tx", tx_a[i], 1);
      chk("reset_ready", ready_a[i], 1);
      chk("reset_busy", busy_a[i], 0);
      chk("reset_level", level_a[i], 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 0xA5, 8N1: hand-computed line pattern, 2-cycle latency, busy timing
    push_one(0, 8'hA5);
    t0 = cyc;
    chk("lat_push_edge_tx", tx_a[0], 1);
    wait_until(t0 + 1); chk("lat_plus1_tx", tx_a[0], 1);
    wait_until(t0 + 2); chk("lat_plus2_tx", tx_a[0], 0);
    for (int k = 0; k < 10; k++) begin
      wait_until(t0 + 2 + 10 * k + 5);
      chk($sformatf("a5_line_bit%0d", k), tx_a[0], pat_a5[k]);
    end
    wait_until(t0 + 100); chk("a5_busy_last", busy_a[0], 1);
    wait_until(t0 + 101); chk("a5_busy_done", busy_a[0], 0);

    // 0x07 with even (u1) and odd (u2) parity
    data_a[1] = 8'h07; data_a[2] = 8'h07;
    valid_a[1] = 1'b1; valid_a[2] = 1'b1;
    @(posedge clk);
    #1;
    valid_a[1] = 1'b0; valid_a[2] = 1'b0;
    t1 = cyc;
    wait_until(t1 + 2);   chk("par_start_even", tx_a[1], 0); chk("par_start_odd", tx_a[2], 0);
    wait_until(t1 + 97);  chk("par_bit_even", tx_a[1], 1);   chk("par_bit_odd", tx_a[2], 0);
    wait_until(t1 + 107); chk("par_stop_even", tx_a[1], 1);  chk("par_stop_odd", tx_a[2], 1);
    wait_until(t1 + 110); chk("par_busy_last_e", busy_a[1], 1); chk("par_busy_last_o", busy_a[2], 1);
    wait_until(t1 + 111); chk("par_busy_done_e", busy_a[1], 0); chk("par_busy_done_o", busy_a[2], 0);

    // Burst of 10 into depth-8 FIFO while idle
    for (int i = 0; i < 9; i++) begin
      push_one(0, burst[i]);
      if (i == 0) tb0 = cyc;
      if (i == 1) chk("push_pop_same_cycle_level", level_a[0], 1);
      if (i == 8) begin
        chk("full_level", level_a[0], 8);
        chk("full_ready", ready_a[0], 0);
      end
    end
    push_one(0, burst[9]);
    chk("tenth_push_cycle", cyc - tb0, 103);
    chk("tenth_push_level", level_a[0], 8);

    // Two stop bits: 0xFF then 0x00
    push_one(3, 8'hFF);
    t3 = cyc;
    push_one(3, 8'h00);
    wait_until(t3 + 2);   chk("stop2_first_start", tx_a[3], 0);
    wait_until(t3 + 92);  chk("stop2_stop_begin", tx_a[3], 1);
    wait_until(t3 + 112); chk("stop2_idle_gap", tx_a[3], 1);
    wait_until(t3 + 113); chk("stop2_second_start", tx_a[3], 0);

    // Drain everything
    waited = 0;
    while (busy_a != '0 && waited < 3000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("drain_idle", busy_a, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("queue_empty_u0", g[0].exp_q.size(), 0);
    chk("queue_empty_u1", g[1].exp_q.size(), 0);
    chk("queue_empty_u2", g[2].exp_q.size(), 0);
    chk("queue_empty_u3", g[3].exp_q.size(), 0);

    // Asynchronous reset in the middle of a start bit with bytes queued
    push_one(0, 8'h3C);
    push_one(0, 8'h5A);
    push_one(0, 8'h66);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_tx", tx_a[0], 0);
    chk("pre_reset_level", level_a[0], 2);
    chk("pre_reset_busy", busy_a[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_tx", tx_a[0], 1);
    chk("async_reset_ready", ready_a[0], 1);
    chk("async_reset_busy", busy_a[0], 0);
    chk("async_reset_level", level_a[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
